// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited requests to an
// in-order variable-latency instruction memory and queues returned words for decode.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int          AW          = $clog2(DEPTH);
    localparam int          CW          = AW + 1;
    localparam logic [CW:0] DEPTH_U     = (CW + 1)'(DEPTH);
    localparam logic [31:0] RESET_PC_AL = RESET_PC & 32'hFFFF_FFFC;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pend_pc_q [DEPTH];
    ptr_t        pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
    cnt_t        outstanding_q, outstanding_d;

    logic [31:0] q_pc_q   [DEPTH];
    logic [31:0] q_data_q [DEPTH];
    ptr_t        q_head_q, q_head_d, q_tail_q, q_tail_d;
    cnt_t        q_count_q, q_count_d;
    cnt_t        drop_q, drop_d;

    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d, inst_pc_q, inst_pc_d;

    logic [CW:0] used;
    logic        req_fire, resp_keep, resp_drop, pop;
    cnt_t        q_left;

    // Handshakes: a transfer happens on a cycle where valid && ready at the rising edge;
    // once raised, imem_req_valid/addr hold until accepted unless a redirect or reset withdraws them.
    assign used           = {1'b0, q_count_q} + {1'b0, outstanding_q};
    assign imem_req_valid = !reset && !redirect_valid && (used < DEPTH_U);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_keep      = imem_resp_valid && !redirect_valid && (drop_q == '0);
    assign resp_drop      = imem_resp_valid && !redirect_valid && (drop_q != '0);
    assign pop            = (q_count_q != '0) && inst_ready && !redirect_valid;
    assign q_left         = q_count_q - cnt_t'(pop);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        pend_wr_d     = pend_wr_q;
        pend_rd_d     = pend_rd_q;
        outstanding_d = outstanding_q;
        q_head_d      = q_head_q;
        q_tail_d      = q_tail_q;
        q_count_d     = q_count_q;
        drop_d        = drop_q;

        if (redirect_valid) begin
            // Everything in flight becomes garbage; a same-cycle response retires one of them.
            fetch_pc_d    = redirect_pc & 32'hFFFF_FFFC;
            pend_wr_d     = '0;
            pend_rd_d     = '0;
            outstanding_d = '0;
            q_head_d      = '0;
            q_tail_d      = '0;
            q_count_d     = '0;
            drop_d        = drop_q + outstanding_q - cnt_t'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                pend_wr_d  = pend_wr_q + ptr_t'(1);
            end
            if (resp_keep) begin
                pend_rd_d = pend_rd_q + ptr_t'(1);
                q_tail_d  = q_tail_q + ptr_t'(1);
            end
            if (resp_drop) begin
                drop_d = drop_q - cnt_t'(1);
            end
            if (pop) begin
                q_head_d = q_head_q + ptr_t'(1);
            end
            outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(resp_keep);
            q_count_d     = q_left + cnt_t'(resp_keep);
        end

        // The head register must see a word pushed this cycle when it lands on an emptied queue.
        inst_valid_d = (q_count_d != '0);
        inst_d       = '0;
        inst_pc_d    = '0;
        if (resp_keep && (q_left == '0)) begin
            inst_d    = imem_resp_data;
            inst_pc_d = pend_pc_q[pend_rd_q];
        end else if (q_count_d != '0) begin
            inst_d    = q_data_q[q_head_d];
            inst_pc_d = q_pc_q[q_head_d];
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pend_pc_q[pend_wr_q] <= fetch_pc_q;
        end
        if (resp_keep) begin
            q_pc_q[q_tail_q]   <= pend_pc_q[pend_rd_q];
            q_data_q[q_tail_q] <= imem_resp_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC_AL;
            pend_wr_q     <= '0;
            pend_rd_q     <= '0;
            outstanding_q <= '0;
            q_head_q      <= '0;
            q_tail_q      <= '0;
            q_count_q     <= '0;
            drop_q        <= '0;
            inst_valid_q  <= 1'b0;
            inst_q        <= '0;
            inst_pc_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            pend_wr_q     <= pend_wr_d;
            pend_rd_q     <= pend_rd_d;
            outstanding_q <= outstanding_d;
            q_head_q      <= q_head_d;
            q_tail_q      <= q_tail_d;
            q_count_q     <= q_count_d;
            drop_q        <= drop_d;
            inst_valid_q  <= inst_valid_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule
